// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter.
// Shares one combinational instruction-memory read port between the fetch
// stage (F) and the debug/trace reader (D). The winning address is registered,
// the memory word and fault information are captured one cycle later, and the
// result is held on a valid/ready response channel until the owner takes it.
// Fetch has priority, but after FETCH_BURST consecutive fetch wins against a
// waiting debug request the debug side is served once.
module imem_port_arbiter #(
    parameter int FETCH_BURST = 4,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    input  logic              f_flush,
    output logic              f_rvalid,
    input  logic              f_rready,
    output logic [31:0]       f_rdata,
    output logic              f_exc_en,
    output logic [3:0]        f_exc_code,
    output logic [ADDR_W-1:0] f_exc_val,

    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    input  logic              d_rready,
    output logic [31:0]       d_rdata,
    output logic              d_exc_en,
    output logic [3:0]        d_exc_code,
    output logic [ADDR_W-1:0] d_exc_val,

    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_instr,
    input  logic              mem_exc_en,
    input  logic [3:0]        mem_exc_code,
    input  logic [ADDR_W-1:0] mem_exc_val
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

    localparam logic [3:0] BURST_MAX = 4'(FETCH_BURST);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          burst_cnt_q, burst_cnt_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                exc_en_q, exc_en_d;
    logic [3:0]          exc_code_q, exc_code_d;
    logic [ADDR_W-1:0]   exc_val_q, exc_val_d;

    logic resp_is_f;
    logic resp_is_d;
    logic f_drop;
    logic retire;
    logic accept;
    logic burst_full;
    logic grant_f;
    logic grant_d;

    // Decide whether the port can take a new request this cycle and who wins it.
    always_comb begin
        resp_is_f  = (state_q == RESP) && (owner_q == OWNER_F);
        resp_is_d  = (state_q == RESP) && (owner_q == OWNER_D);
        f_drop     = resp_is_f && f_flush;
        retire     = (resp_is_f && f_rready) || (resp_is_d && d_rready);
        accept     = !rst && ((state_q == IDLE) || retire || f_drop);
        burst_full = (burst_cnt_q == BURST_MAX);
        grant_f    = accept && f_req && !(d_req && burst_full);
        grant_d    = accept && d_req && !grant_f;
    end

    // Next-state, address, response-capture and anti-starvation counter logic.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        addr_d      = addr_q;
        burst_cnt_d = burst_cnt_q;
        rdata_d     = rdata_q;
        exc_en_d    = exc_en_q;
        exc_code_d  = exc_code_q;
        exc_val_d   = exc_val_q;

        case (state_q)
            IDLE, RESP: begin
                if (grant_f) begin
                    addr_d  = f_addr;
                    owner_d = OWNER_F;
                    state_d = ACCESS;
                end else if (grant_d) begin
                    addr_d  = d_addr;
                    owner_d = OWNER_D;
                    state_d = ACCESS;
                end else if (accept) begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if ((owner_q == OWNER_F) && f_flush) begin
                    state_d = IDLE;
                end else begin
                    rdata_d    = mem_instr;
                    exc_en_d   = mem_exc_en;
                    exc_code_d = mem_exc_code;
                    exc_val_d  = mem_exc_val;
                    state_d    = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!d_req || grant_d) begin
            burst_cnt_d = 4'd0;
        end else if (grant_f && !burst_full) begin
            burst_cnt_d = burst_cnt_q + 4'd1;
        end
    end

    // State and response registers; reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_F;
            addr_q      <= '0;
            burst_cnt_q <= 4'd0;
            rdata_q     <= 32'd0;
            exc_en_q    <= 1'b0;
            exc_code_q  <= 4'd0;
            exc_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            burst_cnt_q <= burst_cnt_d;
            rdata_q     <= rdata_d;
            exc_en_q    <= exc_en_d;
            exc_code_q  <= exc_code_d;
            exc_val_q   <= exc_val_d;
        end
    end

    assign f_gnt      = grant_f;
    assign d_gnt      = grant_d;
    assign f_rvalid   = resp_is_f && !f_flush;
    assign d_rvalid   = resp_is_d;
    assign mem_addr   = addr_q;

    assign f_rdata    = rdata_q;
    assign f_exc_en   = exc_en_q;
    assign f_exc_code = exc_code_q;
    assign f_exc_val  = exc_val_q;
    assign d_rdata    = rdata_q;
    assign d_exc_en   = exc_en_q;
    assign d_exc_code = exc_code_q;
    assign d_exc_val  = exc_val_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter.
// A combinational memory model answers every address with a word and fault
// information derived from the address. A transaction-level reference model
// tracks the single outstanding access and predicts grants, valids and payload.
module tb_imem_port_arbiter;

    localparam int FB     = 4;
    localparam int ADDR_W = 64;

    logic              clk;
    logic              rst;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_flush;
    logic              f_rvalid;
    logic              f_rready;
    logic [31:0]       f_rdata;
    logic              f_exc_en;
    logic [3:0]        f_exc_code;
    logic [ADDR_W-1:0] f_exc_val;
    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_gnt;
    logic              d_rvalid;
    logic              d_rready;
    logic [31:0]       d_rdata;
    logic              d_exc_en;
    logic [3:0]        d_exc_code;
    logic [ADDR_W-1:0] d_exc_val;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_instr;
    logic              mem_exc_en;
    logic [3:0]        mem_exc_code;
    logic [ADDR_W-1:0] mem_exc_val;

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: one outstanding transaction, aged in cycles since grant.
    bit                m_have;
    bit                m_from_f;
    logic [ADDR_W-1:0] m_addr;
    logic [ADDR_W-1:0] m_last;
    int                m_age;
    int                m_streak;

    imem_port_arbiter #(.FETCH_BURST(FB), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_flush(f_flush),
        .f_rvalid(f_rvalid), .f_rready(f_rready), .f_rdata(f_rdata),
        .f_exc_en(f_exc_en), .f_exc_code(f_exc_code), .f_exc_val(f_exc_val),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rready(d_rready), .d_rdata(d_rdata),
        .d_exc_en(d_exc_en), .d_exc_code(d_exc_code), .d_exc_val(d_exc_val),
        .mem_addr(mem_addr), .mem_instr(mem_instr), .mem_exc_en(mem_exc_en),
        .mem_exc_code(mem_exc_code), .mem_exc_val(mem_exc_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13572468;
    endfunction

    function automatic logic fault_of(input logic [ADDR_W-1:0] a);
        return a[19:16] == 4'h4;
    endfunction

    function automatic logic [3:0] code_of(input logic [ADDR_W-1:0] a);
        return fault_of(a) ? (a[7:4] + 4'd1) : 4'd0;
    endfunction

    function automatic logic [ADDR_W-1:0] val_of(input logic [ADDR_W-1:0] a);
        return fault_of(a) ? a : '0;
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = '0;
        a[19:16] = 4'($urandom_range(0, 15));
        a[15:0]  = 16'($urandom) & 16'hFFFC;
        return a;
    endfunction

    // Memory: purely combinational view of the address the arbiter presents.
    always_comb begin
        mem_instr    = word_of(mem_addr);
        mem_exc_en   = fault_of(mem_addr);
        mem_exc_code = code_of(mem_addr);
        mem_exc_val  = val_of(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_have   = 0;
        m_from_f = 0;
        m_addr   = '0;
        m_last   = '0;
        m_age    = 0;
        m_streak = 0;
    endtask

    // One cycle: inputs are already driven after a negedge; check, predict, advance.
    task automatic cycle();
        bit resp, opp, e_fg, e_dg, e_fv, e_dv;
        #1;
        resp = m_have && (m_age >= 2);
        opp  = !m_have || (resp && (m_from_f ? (f_rready || f_flush) : d_rready));
        e_fg = opp && f_req && !(d_req && (m_streak == FB));
        e_dg = opp && d_req && !e_fg;
        e_fv = resp && m_from_f && !f_flush;
        e_dv = resp && !m_from_f;

        check("f_gnt", 64'(f_gnt), 64'(e_fg));
        check("d_gnt", 64'(d_gnt), 64'(e_dg));
        check("f_rvalid", 64'(f_rvalid), 64'(e_fv));
        check("d_rvalid", 64'(d_rvalid), 64'(e_dv));
        check("mem_addr", mem_addr, m_last);
        if (resp) begin
            check("f_rdata", 64'(f_rdata), 64'(word_of(m_addr)));
            check("d_rdata", 64'(d_rdata), 64'(word_of(m_addr)));
            check("f_exc_en", 64'(f_exc_en), 64'(fault_of(m_addr)));
            check("d_exc_en", 64'(d_exc_en), 64'(fault_of(m_addr)));
            check("f_exc_code", 64'(f_exc_code), 64'(code_of(m_addr)));
            check("d_exc_code", 64'(d_exc_code), 64'(code_of(m_addr)));
            check("f_exc_val", f_exc_val, val_of(m_addr));
            check("d_exc_val", d_exc_val, val_of(m_addr));
        end

        if (m_have && (m_age == 1)) begin
            if (m_from_f && f_flush) m_have = 0;
            else m_age = 2;
        end else if (opp) begin
            m_have = 0;
        end
        if (e_fg || e_dg) begin
            m_have   = 1;
            m_from_f = e_fg;
            m_addr   = e_fg ? f_addr : d_addr;
            m_age    = 1;
            m_last   = m_addr;
        end
        if (!d_req || e_dg) m_streak = 0;
        else if (e_fg && (m_streak < FB)) m_streak++;

        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic fr, input logic [63:0] fa, input logic ff,
                                 input logic frr, input logic dr, input logic [63:0] da,
                                 input logic drr);
        f_req    = fr;
        f_addr   = fa;
        f_flush  = ff;
        f_rready = frr;
        d_req    = dr;
        d_addr   = da;
        d_rready = drr;
        cycle();
    endtask

    initial begin
        int d_grants;
        int f_grants;
        model_reset();
        f_req = 0; f_addr = '0; f_flush = 0; f_rready = 0;
        d_req = 0; d_addr = '0; d_rready = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_addr", mem_addr, 64'h0);
        check("rst_f_rvalid", 64'(f_rvalid), 64'h0);
        check("rst_d_rvalid", 64'(d_rvalid), 64'h0);
        check("rst_f_rdata", 64'(f_rdata), 64'h0);
        check("rst_f_exc_en", 64'(f_exc_en), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] fetch-only access and back-to-back grant");
        applyStimulus(1, 64'h100, 0, 1, 0, 0, 0);
        applyStimulus(0, 64'h0,   0, 1, 0, 0, 0);
        applyStimulus(1, 64'h104, 0, 1, 0, 0, 0);
        applyStimulus(0, 64'h0,   0, 1, 0, 0, 0);
        applyStimulus(0, 64'h0,   0, 1, 0, 0, 0);
        applyStimulus(0, 64'h0,   0, 1, 0, 0, 0);

        $display("[TB] both requesting: anti-starvation order");
        d_grants = 0;
        f_grants = 0;
        for (int i = 0; i < 20; i++) begin
            f_req = 1; f_addr = 64'h1000 + 64'(4 * i); f_flush = 0; f_rready = 1;
            d_req = 1; d_addr = 64'h8000 + 64'(4 * i); d_rready = 1;
            #1;
            if (d_gnt) d_grants++;
            if (f_gnt) f_grants++;
            #(-1 + 1);
            cycle();
        end
        check("burst_f_grants", 64'(f_grants), 64'd8);
        check("burst_d_grants", 64'(d_grants), 64'd2);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);

        $display("[TB] backpressure holds response");
        applyStimulus(1, 64'h2220, 0, 0, 0, 0, 0);
        applyStimulus(1, 64'h2224, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 64'h2228, 0, 0, 0, 0, 0);
        applyStimulus(1, 64'h222C, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        $display("[TB] access fault returned with the word");
        applyStimulus(1, 64'h40000, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("fault_rvalid", 64'(f_rvalid), 64'h1);
        check("fault_en", 64'(f_exc_en), 64'h1);
        check("fault_code", 64'(f_exc_code), 64'h1);
        check("fault_val", f_exc_val, 64'h40000);
        @(negedge clk);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);

        $display("[TB] flush in ACCESS and in RESP");
        applyStimulus(1, 64'h500, 0, 0, 0, 0, 0);
        applyStimulus(0, 0,       1, 0, 0, 0, 0);
        applyStimulus(0, 0,       0, 0, 0, 0, 0);
        applyStimulus(1, 64'h600, 0, 0, 0, 0, 0);
        applyStimulus(0, 0,       0, 0, 0, 0, 0);
        applyStimulus(1, 64'h200, 1, 0, 0, 0, 0);
        applyStimulus(0, 0,       0, 0, 0, 0, 0);
        applyStimulus(0, 0,       0, 1, 0, 0, 0);

        $display("[TB] flush ignored while debug owns the port");
        applyStimulus(0, 0, 1, 0, 1, 64'h7700, 0);
        applyStimulus(0, 0, 1, 0, 0, 0,        0);
        applyStimulus(0, 0, 1, 0, 0, 0,        0);
        applyStimulus(0, 0, 1, 0, 0, 0,        1);
        applyStimulus(0, 0, 0, 0, 0, 0,        0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 99) < 60), rand_addr(),
                          1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 70),
                          1'($urandom_range(0, 99) < 50), rand_addr(),
                          1'($urandom_range(0, 99) < 70));
        end
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);

        $display("[TB] asynchronous reset while a response is held");
        applyStimulus(1, 64'h300, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        #2;
        check("pre_rst_f_rvalid", 64'(f_rvalid), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_f_rvalid", 64'(f_rvalid), 64'h0);
        check("mid_rst_d_rvalid", 64'(d_rvalid), 64'h0);
        check("mid_rst_mem_addr", mem_addr, 64'h0);
        check("mid_rst_f_rdata", 64'(f_rdata), 64'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(1, 64'h304, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
Shares the single combinational instruction-memory read port between two requesters: the CPU fetch stage (F) and the debug/trace reader (D). It registers the winning address, samples the memory's instruction word and access-fault outputs one cycle later, and returns them on a held valid/ready response channel. Fetch has priority, bounded by an anti-starvation counter. A fetch flush input discards in-flight fetch work on PC redirect.

Parameters:
FETCH_BURST, 4, max consecutive F grants while D is waiting; legal range 1..15.
ADDR_W, 64, address width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
f_req  in  1  fetch request
f_addr  in  ADDR_W  fetch byte address
f_gnt  out  1  F request accepted this cycle (combinational)
f_flush  in  1  drop any in-flight or pending F response
f_rvalid  out  1  F response valid
f_rready  in  1  F consumer accepts response
f_rdata  out  32  instruction word
f_exc_en  out  1  access fault for this response
f_exc_code  out  4  fault cause
f_exc_val  out  ADDR_W  faulting address
d_req, d_addr, d_gnt, d_rvalid, d_rready, d_rdata, d_exc_en, d_exc_code, d_exc_val: same as F, debug side; no flush
mem_addr  out  ADDR_W  address to instruction memory
mem_instr  in  32  memory read data
mem_exc_en  in  1  memory fault flag
mem_exc_code  in  4  memory fault cause
mem_exc_val  in  ADDR_W  memory fault value

Behaviour:
- Reset (async): state=IDLE; addr_q=0; owner=F; burst_cnt=0; response registers (rdata, exc_en, exc_code, exc_val)=0. All gnt/rvalid=0, mem_addr=0.
- mem_addr = addr_q at all times.
- States: IDLE, ACCESS, RESP.
- Accept opportunity: the cycle is IDLE, or RESP with the owner's rready=1 (response retires that edge).
- Arbitration at accept: only one req -> grant it. Both -> grant F unless burst_cnt==FETCH_BURST, then grant D.
- Exactly one gnt high at most; on grant edge: addr_q<=addr, owner<=winner, state<=ACCESS.
- No req at an accept opportunity -> IDLE.
- burst_cnt: +1 on an F grant while d_req=1 (saturating at FETCH_BURST); cleared on D grant or any cycle d_req=0.
- ACCESS: at clock edge, capture mem_instr/mem_exc_* into response regs; state<=RESP. No grants in ACCESS.
- RESP: owner's rvalid=1; data/exc stable until rready. Non-owner rvalid=0. Response payload is driven identically to both sides; only rvalid qualifies.
- Latency: grant at edge T -> rvalid visible in cycle T+2; sustained throughput one access per 2 cycles.
- f_flush (owner=F): in ACCESS -> state<=IDLE, nothing captured; in RESP -> f_rvalid forced 0 that cycle, response dropped, treated as accept opportunity (new grants allowed, including F with the new f_addr). f_gnt is suppressed only if f_flush coincides with f_req from IDLE? No: flush does not block a same-cycle new F grant from IDLE/RESP.
- f_flush with owner=D or IDLE: no effect.
- Exception captured with the word; arbiter never generates faults itself. exc_en=1 responses still require rready.
- Reset mid-operation: any state returns to IDLE immediately, response lost, no rvalid.

Test Plan:
- F only: f_req=1, f_addr=0x100 at edge 0 -> f_gnt cycle 0, mem_addr=0x100 cycle 1, f_rvalid=1 cycle 2 with f_rdata=mem word at 0x100; f_rready=1 -> next grant same cycle.
- Both requesting continuously, FETCH_BURST=4 -> grant order F,F,F,F,D,F,F,F,F,D; d_rvalid only on D slots.
- Backpressure: F response at cycle 2, f_rready=0 for 3 cycles -> f_rvalid/f_rdata held stable, no new grant until f_rready=1.
- Fault: mem returns exc_en=1, code=1, val=0x40000 for addr 0x40000 -> f_exc_en=1, f_exc_code=1, f_exc_val=0x40000 with f_rvalid.
- Flush: f_flush in ACCESS -> no f_rvalid for that request; f_flush in RESP with f_req=1, f_addr=0x200 -> f_gnt same cycle, next response from 0x200.
- Async reset asserted in RESP mid-cycle -> rvalid drops immediately, mem_addr=0, state IDLE after release.
